// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA timing constants and the RGB444 pixel type.
package vga_timing_pkg;
   localparam int H_TOTAL      = 800;
   localparam int V_TOTAL      = 525;
   localparam int H_SYNC_START = 656;
   localparam int V_SYNC_START = 490;
   localparam int FB_ADDR_W    = 17;
   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;
endpackage

// File: rtl/rgb444_to_gray.sv
// rgb444_to_gray: expand RGB444 nibbles to 8 bits and form luma (77R+150G+29B)>>8.
module rgb444_to_gray
   import vga_timing_pkg::*;
(
   input  logic [11:0] px,
   output logic [7:0]  gray
);
   rgb444_t     c;
   logic [15:0] acc;
   assign c    = px;
   assign acc  = 16'd77 * {8'd0, c.r, c.r} + 16'd150 * {8'd0, c.g, c.g} + 16'd29 * {8'd0, c.b, c.b};
   assign gray = 8'(acc >> 8);
endmodule

// File: rtl/vga_gray_stream_gen.sv
// vga_gray_stream_gen: VGA timing source reading a 2x-upscaled RGB444 frame buffer as 8-bit gray.
// Defining VGA_TEST_PATTERN_EN adds pattern_sel, which swaps camera gray for an x_pixel ramp.
module vga_gray_stream_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int FB_WIDTH  = 320
) (
   input  logic        clk,
   input  logic        rst,
`ifdef VGA_TEST_PATTERN_EN
   input  logic        pattern_sel,
`endif
   input  logic [11:0] fb_rdata,
   output logic [16:0] fb_raddr,
   output logic        fb_re,
   output logic        pix_tick,
   output logic        h_sync,
   output logic        v_sync,
   output logic [9:0]  x_pixel,
   output logic [9:0]  y_pixel,
   output logic        disp_enable,
   output logic [7:0]  gray_out,
   output logic        frame_start
);
   localparam int DW  = $clog2(CLK_DIV);
   localparam int HT  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int VT  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HSS = H_VISIBLE + H_FP;
   localparam int VSS = V_VISIBLE + V_FP;

   logic [DW-1:0]        div_q, div_d;
   logic [9:0]           h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d, h_nx, v_nx;
   logic                 de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, p1_q, p1_d, p2_q, p2_d;
   logic                 tick, de_nx;
   logic [FB_ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]           gray_q, gray_d, cam_gray, src_gray;

   rgb444_to_gray u_gray (.px(fb_rdata), .gray(cam_gray));

`ifdef VGA_TEST_PATTERN_EN
   assign src_gray = pattern_sel ? x_q[9:2] : cam_gray;
`else
   assign src_gray = cam_gray;
`endif

   always_comb begin
      tick   = div_q == DW'(CLK_DIV - 1);
      h_nx   = h_q == 10'(HT - 1) ? 10'd0 : h_q + 10'd1;
      v_nx   = h_q != 10'(HT - 1) ? v_q : v_q == 10'(VT - 1) ? 10'd0 : v_q + 10'd1;
      de_nx  = h_nx < 10'(H_VISIBLE) && v_nx < 10'(V_VISIBLE);
      div_d  = tick ? '0 : div_q + DW'(1);
      h_d    = tick ? h_nx : h_q;
      v_d    = tick ? v_nx : v_q;
      x_d    = tick ? h_nx : x_q;
      y_d    = tick ? v_nx : y_q;
      de_d   = tick ? de_nx : de_q;
      hs_d   = tick ? !(h_nx >= 10'(HSS) && h_nx < 10'(HSS + H_SYNC)) : hs_q;
      vs_d   = tick ? !(v_nx >= 10'(VSS) && v_nx < 10'(VSS + V_SYNC)) : vs_q;
      fs_d   = tick && h_nx == 10'd0 && v_nx == 10'd0;
      addr_d = tick && de_nx ? FB_ADDR_W'(v_nx[9:1]) * FB_ADDR_W'(FB_WIDTH) + FB_ADDR_W'(h_nx[9:1]) : addr_q;
      p1_d   = tick;
      p2_d   = p1_q;
      // frame-buffer data lands one clk after the address, so gray is captured two clks after the tick
      gray_d = p2_q ? (de_q ? src_gray : 8'd0) : gray_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_q  <= '0;
         h_q    <= 10'(HT - 1);
         v_q    <= 10'(VT - 1);
         x_q    <= '0;
         y_q    <= '0;
         de_q   <= 1'b0;
         hs_q   <= 1'b1;
         vs_q   <= 1'b1;
         fs_q   <= 1'b0;
         addr_q <= '0;
         p1_q   <= 1'b0;
         p2_q   <= 1'b0;
         gray_q <= '0;
      end else begin
         div_q  <= div_d;
         h_q    <= h_d;
         v_q    <= v_d;
         x_q    <= x_d;
         y_q    <= y_d;
         de_q   <= de_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         fs_q   <= fs_d;
         addr_q <= addr_d;
         p1_q   <= p1_d;
         p2_q   <= p2_d;
         gray_q <= gray_d;
      end
   end

   assign pix_tick    = tick;
   assign x_pixel     = x_q;
   assign y_pixel     = y_q;
   assign disp_enable = de_q;
   assign fb_re       = de_q;
   assign h_sync      = hs_q;
   assign v_sync      = vs_q;
   assign frame_start = fs_q;
   assign fb_raddr    = addr_q;
   assign gray_out    = gray_q;
endmodule

// File: tb/tb_vga_gray_stream_gen.sv
// tb_vga_gray_stream_gen: directed checks of a full-size instance plus a shrunken-geometry instance for frame timing.
module tb_vga_gray_stream_gen;
   logic        clk = 1'b0;
   logic        rst, rst_b;
   logic [11:0] fb_val;
   logic [11:0] fb_rdata = 12'h000;
   logic [16:0] fb_raddr, addr_b;
   logic        fb_re, pix_tick, h_sync, v_sync, disp_enable, frame_start;
   logic        re_b, tick_b, hs_b, vs_b, de_b, fs_b;
   logic [9:0]  x_pixel, y_pixel, x_b, y_b;
   logic [7:0]  gray_out, gray_b;
   int          vectors = 0, miscompares = 0, cycles = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (fb_re) fb_rdata <= fb_val;

   vga_gray_stream_gen u_dut (
      .clk(clk), .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
      .pattern_sel(1'b0),
`endif
      .fb_rdata(fb_rdata), .fb_raddr(fb_raddr), .fb_re(fb_re), .pix_tick(pix_tick),
      .h_sync(h_sync), .v_sync(v_sync), .x_pixel(x_pixel), .y_pixel(y_pixel),
      .disp_enable(disp_enable), .gray_out(gray_out), .frame_start(frame_start)
   );

   // 23x12 pixel frame, 3 clks/pixel, 8-wide buffer: whole frames fit in a short run
   vga_gray_stream_gen #(
      .CLK_DIV(3), .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .FB_WIDTH(8)
   ) u_small (
      .clk(clk), .rst(rst_b),
`ifdef VGA_TEST_PATTERN_EN
      .pattern_sel(1'b0),
`endif
      .fb_rdata(12'h000), .fb_raddr(addr_b), .fb_re(re_b), .pix_tick(tick_b),
      .h_sync(hs_b), .v_sync(vs_b), .x_pixel(x_b), .y_pixel(y_b),
      .disp_enable(de_b), .gray_out(gray_b), .frame_start(fs_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
      cycles++;
   endtask

   task automatic next_pixel();
      int n = 0;
      while (!pix_tick && n < 10) begin step(); n++; end
      if (!pix_tick) begin vectors++; miscompares++; $display("FAIL tick_timeout: no pix_tick within 10 clks"); end
      step();
   endtask

   task automatic walk_to(input int wx, input int wy);
      int n = 0;
      while (!(x_pixel == 10'(wx) && y_pixel == 10'(wy)) && n < 5000) begin next_pixel(); n++; end
      vectors++; if (x_pixel != 10'(wx) || y_pixel != 10'(wy)) begin miscompares++; $display("FAIL walk_to: got (%0d,%0d) want (%0d,%0d)", x_pixel, y_pixel, wx, wy); end
   endtask

   task automatic test_reset();
      int t;
      rst = 1'b0;
      repeat (10) step();
      vectors++; if (x_pixel !== 10'd0) begin miscompares++; $display("FAIL rst_x: got %0d want 0", x_pixel); end
      vectors++; if (y_pixel !== 10'd0) begin miscompares++; $display("FAIL rst_y: got %0d want 0", y_pixel); end
      vectors++; if (disp_enable !== 1'b0) begin miscompares++; $display("FAIL rst_de: got %b want 0", disp_enable); end
      vectors++; if (h_sync !== 1'b1) begin miscompares++; $display("FAIL rst_hs: got %b want 1", h_sync); end
      vectors++; if (v_sync !== 1'b1) begin miscompares++; $display("FAIL rst_vs: got %b want 1", v_sync); end
      vectors++; if (fb_re !== 1'b0) begin miscompares++; $display("FAIL rst_re: got %b want 0", fb_re); end
      vectors++; if (fb_raddr !== 17'd0) begin miscompares++; $display("FAIL rst_addr: got %0d want 0", fb_raddr); end
      vectors++; if (gray_out !== 8'd0) begin miscompares++; $display("FAIL rst_gray: got %0d want 0", gray_out); end
      vectors++; if (pix_tick !== 1'b0) begin miscompares++; $display("FAIL rst_tick: got %b want 0", pix_tick); end
      vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL rst_fs: got %b want 0", frame_start); end
      rst = 1'b1;
      t = cycles;
      next_pixel();
      vectors++; if (cycles - t != 4) begin miscompares++; $display("FAIL first_tick: got %0d clks want 4", cycles - t); end
      vectors++; if (x_pixel !== 10'd0 || y_pixel !== 10'd0) begin miscompares++; $display("FAIL first_xy: got (%0d,%0d) want (0,0)", x_pixel, y_pixel); end
      vectors++; if (disp_enable !== 1'b1) begin miscompares++; $display("FAIL first_de: got %b want 1", disp_enable); end
      vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL first_fs: got %b want 1", frame_start); end
      vectors++; if (fb_re !== 1'b1) begin miscompares++; $display("FAIL first_re: got %b want 1", fb_re); end
      t = cycles;
      step();
      vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL fs_width: got %b want 0", frame_start); end
      next_pixel();
      vectors++; if (cycles - t != 4) begin miscompares++; $display("FAIL tick_spacing: got %0d clks want 4", cycles - t); end
      vectors++; if (x_pixel !== 10'd1) begin miscompares++; $display("FAIL second_x: got %0d want 1", x_pixel); end
   endtask

   task automatic test_gray();
      logic [11:0] gv [5] = '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'h000};
      logic [7:0]  ge [5] = '{8'd255, 8'd76, 8'd149, 8'd28, 8'd0};
      logic [7:0]  prev = 8'd0;
      for (int i = 0; i < 5; i++) begin
         next_pixel();
         fb_val = gv[i];
         step();
         vectors++; if (gray_out !== prev) begin miscompares++; $display("FAIL gray_hold[%0d]: got %0d want %0d", i, gray_out, prev); end
         step();
         vectors++; if (gray_out !== ge[i]) begin miscompares++; $display("FAIL gray[%03h]: got %0d want %0d", gv[i], gray_out, ge[i]); end
         step();
         vectors++; if (gray_out !== ge[i]) begin miscompares++; $display("FAIL gray_stable[%03h]: got %0d want %0d", gv[i], gray_out, ge[i]); end
         prev = ge[i];
      end
   endtask

   task automatic test_line();
      int hs_low = 0, hs_first = -1, de_first = -1, prev_x = -1, t0, n = 0;
      fb_val = 12'hFFF;
      do begin
         prev_x = int'(x_pixel);
         next_pixel();
         n++;
         if (!h_sync) begin hs_low++; if (hs_first < 0) hs_first = int'(x_pixel); end
         if (!disp_enable && de_first < 0) de_first = int'(x_pixel);
         if (x_pixel == 10'd639) begin
            vectors++; if (fb_raddr !== 17'd319) begin miscompares++; $display("FAIL addr_639_0: got %0d want 319", fb_raddr); end
         end
         if (x_pixel == 10'd640) begin
            vectors++; if (fb_re !== 1'b0) begin miscompares++; $display("FAIL re_640: got %b want 0", fb_re); end
            vectors++; if (fb_raddr !== 17'd319) begin miscompares++; $display("FAIL addr_hold_640: got %0d want 319", fb_raddr); end
            step();
            step();
            vectors++; if (gray_out !== 8'd0) begin miscompares++; $display("FAIL gray_blank: got %0d want 0", gray_out); end
         end
      end while (x_pixel != 10'd0 && n < 1000);
      vectors++; if (prev_x != 799 || x_pixel !== 10'd0) begin miscompares++; $display("FAIL x_wrap: got %0d->%0d want 799->0", prev_x, x_pixel); end
      vectors++; if (y_pixel !== 10'd1) begin miscompares++; $display("FAIL y_inc: got %0d want 1", y_pixel); end
      vectors++; if (hs_low != 96) begin miscompares++; $display("FAIL hs_width: got %0d want 96", hs_low); end
      vectors++; if (hs_first != 656) begin miscompares++; $display("FAIL hs_start: got %0d want 656", hs_first); end
      vectors++; if (de_first != 640) begin miscompares++; $display("FAIL de_end: got %0d want 640", de_first); end
      t0 = cycles;
      n = 0;
      do begin next_pixel(); n++; end while (x_pixel != 10'd0 && n < 1000);
      vectors++; if (cycles - t0 != 3200) begin miscompares++; $display("FAIL line_period: got %0d clks want 3200", cycles - t0); end
      vectors++; if (y_pixel !== 10'd2) begin miscompares++; $display("FAIL y_line2: got %0d want 2", y_pixel); end
   endtask

   task automatic test_addr();
      walk_to(7, 3);
      vectors++; if (fb_raddr !== 17'd323) begin miscompares++; $display("FAIL addr_7_3: got %0d want 323", fb_raddr); end
      walk_to(3, 5);
      vectors++; if (fb_raddr !== 17'd641) begin miscompares++; $display("FAIL addr_3_5: got %0d want 641", fb_raddr); end
      vectors++; if (fb_re !== 1'b1) begin miscompares++; $display("FAIL re_3_5: got %b want 1", fb_re); end
   endtask

   task automatic test_reset_mid();
      int t;
      walk_to(300, 5);
      step();
      step();
      vectors++; if (gray_out !== 8'd255) begin miscompares++; $display("FAIL gray_pre_rst: got %0d want 255", gray_out); end
      rst = 1'b0;
      step();
      vectors++; if (gray_out !== 8'd0) begin miscompares++; $display("FAIL gray_in_rst: got %0d want 0", gray_out); end
      step();
      step();
      vectors++; if (h_sync !== 1'b1) begin miscompares++; $display("FAIL hs_in_rst: got %b want 1", h_sync); end
      vectors++; if (x_pixel !== 10'd0 || y_pixel !== 10'd0) begin miscompares++; $display("FAIL xy_in_rst: got (%0d,%0d) want (0,0)", x_pixel, y_pixel); end
      vectors++; if (disp_enable !== 1'b0 || fb_re !== 1'b0) begin miscompares++; $display("FAIL de_re_in_rst: got %b/%b want 0/0", disp_enable, fb_re); end
      rst = 1'b1;
      t = cycles;
      next_pixel();
      vectors++; if (cycles - t != 4) begin miscompares++; $display("FAIL rel_tick: got %0d clks want 4", cycles - t); end
      vectors++; if (x_pixel !== 10'd0 || y_pixel !== 10'd0) begin miscompares++; $display("FAIL rel_xy: got (%0d,%0d) want (0,0)", x_pixel, y_pixel); end
      vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL rel_fs: got %b want 1", frame_start); end
   endtask

   task automatic test_frame();
      int fs_cnt = 0, vs_ticks = 0, vs_min = 99, vs_max = -1, y_prev = 0, y_wrap = -1, max_addr = 0, n = 0, dbl = 0;
      int fs_t [3] = '{0, 0, 0};
      logic fs_prev = 1'b0;
      rst_b = 1'b1;
      while (fs_cnt < 3 && n < 4000) begin
         step();
         n++;
         if (fs_b) begin
            if (fs_cnt < 3) fs_t[fs_cnt] = n;
            fs_cnt++;
            if (fs_cnt == 2) y_wrap = y_prev;
         end
         if (fs_b && fs_prev) dbl++;
         fs_prev = fs_b;
         if (fs_cnt == 1 && tick_b && !vs_b) begin
            vs_ticks++;
            if (int'(y_b) < vs_min) vs_min = int'(y_b);
            if (int'(y_b) > vs_max) vs_max = int'(y_b);
         end
         if (re_b && int'(addr_b) > max_addr) max_addr = int'(addr_b);
         if (x_b == 10'd15 && y_b == 10'd7 && tick_b) begin
            vectors++; if (addr_b !== 17'd31) begin miscompares++; $display("FAIL addr_last_visible: got %0d want 31", addr_b); end
         end
         y_prev = int'(y_b);
      end
      vectors++; if (fs_cnt != 3) begin miscompares++; $display("FAIL frame_timeout: got %0d frame_starts want 3", fs_cnt); end
      vectors++; if (fs_t[0] != 3) begin miscompares++; $display("FAIL small_first_fs: got clk %0d want 3", fs_t[0]); end
      vectors++; if (fs_t[1] - fs_t[0] != 828 || fs_t[2] - fs_t[1] != 828) begin miscompares++; $display("FAIL frame_period: got %0d,%0d want 828", fs_t[1] - fs_t[0], fs_t[2] - fs_t[1]); end
      vectors++; if (dbl != 0) begin miscompares++; $display("FAIL fs_single: got %0d long pulses want 0", dbl); end
      vectors++; if (vs_ticks != 46 || vs_min != 9 || vs_max != 10) begin miscompares++; $display("FAIL vsync: got %0d ticks lines %0d..%0d want 46 lines 9..10", vs_ticks, vs_min, vs_max); end
      vectors++; if (y_wrap != 11) begin miscompares++; $display("FAIL y_wrap: got %0d want 11", y_wrap); end
      vectors++; if (max_addr != 31) begin miscompares++; $display("FAIL max_addr: got %0d want 31", max_addr); end
   endtask

   initial begin
      rst    = 1'b0;
      rst_b  = 1'b0;
      fb_val = 12'h000;
      test_reset();
      test_gray();
      test_line();
      test_addr();
      test_reset_mid();
      test_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
